// File: rtl/boot_sequencer_pkg.sv
// Shared definitions for the boot sequencer: FSM state encoding, access-size codes, default load address.
package boot_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PRIME = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } boot_state_e;

    localparam logic [1:0]  ACC_SIZE_WORD   = 2'b00;
    localparam logic [31:0] BOOT_START_ADDR = 32'h8002_0000;

endpackage

// File: rtl/boot_fetch_delay.sv
// MEM_LAT-deep shift register carrying fetch address and valid from issue to decode; frozen while step_i is low.
module boot_fetch_delay
    import boot_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DEPTH      = 2,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(BOOT_START_ADDR)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              valid_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= START_ADDR;
            end
            valid_q <= '0;
        end else if (step_i) begin
            addr_q[0]  <= addr_i;
            valid_q[0] <= valid_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                addr_q[i]  <= addr_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign addr_o  = addr_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: streams an image into memory, then fetches it back through a MEM_LAT pipeline.
// Optional build macro BOOT_SEQ_CHECKSUM_EN adds an XOR checksum output over accepted load words.
module boot_sequencer
    import boot_sequencer_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(BOOT_START_ADDR),
    parameter int unsigned       MAX_WORDS  = 1024,
    parameter int unsigned       MEM_LAT    = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               go,
    input  logic                               load_valid,
    input  logic [DATA_W-1:0]                  load_data,
    input  logic                               load_last,
    output logic                               load_ready,
    input  logic                               mem_busy,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_data_in,
    output logic                               mem_wren,
    output logic                               mem_enable,
    output logic [1:0]                         mem_acc_size,
    input  logic                               hold,
    output logic [ADDR_W-1:0]                  pc,
    output logic [ADDR_W-1:0]                  pc_in,
    output logic                               valid_insn,
    output logic [$clog2(MAX_WORDS+1)-1:0]     word_count,
    output logic                               busy,
    output logic                               done,
`ifdef BOOT_SEQ_CHECKSUM_EN
    output logic [DATA_W-1:0]                  checksum,
`endif
    output logic                               overflow
);

    localparam int unsigned       WC_W       = $clog2(MAX_WORDS + 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(DATA_W / 8);
    localparam logic [WC_W-1:0]   MAX_WC     = WC_W'(MAX_WORDS);
    localparam logic [2:0]        PRIME_LAST = 3'(MEM_LAT - 1);

    boot_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic [WC_W-1:0]   issue_q, issue_d;
    logic [WC_W-1:0]   retired_q, retired_d;
    logic [2:0]        prime_q, prime_d;
    logic              overflow_q, overflow_d;

    logic              stall, issue_valid, beat, step, flush;
    logic [ADDR_W-1:0] dly_addr;
    logic              dly_valid;

    assign stall       = hold || mem_busy;
    assign issue_valid = issue_q < wc_q;
    assign flush       = (state_q == S_IDLE) || (state_q == S_LOAD);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wc_d        = wc_q;
        issue_d     = issue_q;
        retired_d   = retired_q;
        prime_d     = prime_q;
        overflow_d  = overflow_q;
        load_ready  = 1'b0;
        beat        = 1'b0;
        step        = 1'b0;
        mem_wren    = 1'b0;
        mem_enable  = 1'b0;
        mem_data_in = '0;
        mem_addr    = addr_q;
        valid_insn  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_d    = S_LOAD;
                    addr_d     = START_ADDR;
                    wc_d       = '0;
                    overflow_d = 1'b0;
                end
            end
            S_LOAD: begin
                load_ready = !mem_busy && (wc_q < MAX_WC);
                beat       = load_valid && load_ready;
                if (beat) begin
                    mem_wren    = 1'b1;
                    mem_enable  = 1'b1;
                    mem_data_in = load_data;
                    addr_d      = addr_q + ADDR_STEP;
                    wc_d        = wc_q + WC_W'(1);
                    if (load_last || (wc_d == MAX_WC)) begin
                        state_d    = S_PRIME;
                        overflow_d = !load_last;
                        addr_d     = START_ADDR;
                        issue_d    = '0;
                        retired_d  = '0;
                        prime_d    = '0;
                    end
                end
            end
            S_PRIME, S_RUN: begin
                // Past the last loaded word the pc keeps stepping but no request is raised.
                mem_enable = issue_valid && !stall;
                step       = !stall;
                valid_insn = (state_q == S_RUN) && dly_valid;
                if (step) begin
                    addr_d = addr_q + ADDR_STEP;
                    if (issue_valid) issue_d = issue_q + WC_W'(1);
                    if (state_q == S_PRIME) begin
                        prime_d = prime_q + 3'd1;
                        if (prime_q == PRIME_LAST) state_d = S_RUN;
                    end else if (dly_valid) begin
                        retired_d = retired_q + WC_W'(1);
                        if (retired_d == wc_q) state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= START_ADDR;
            wc_q       <= '0;
            issue_q    <= '0;
            retired_q  <= '0;
            prime_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wc_q       <= wc_d;
            issue_q    <= issue_d;
            retired_q  <= retired_d;
            prime_q    <= prime_d;
            overflow_q <= overflow_d;
        end
    end

    boot_fetch_delay #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (MEM_LAT),
        .START_ADDR(START_ADDR)
    ) u_fetch_delay (
        .clk_i  (clock),
        .rst_i  (reset),
        .flush_i(flush),
        .step_i (step),
        .addr_i (addr_q),
        .valid_i(issue_valid),
        .addr_o (dly_addr),
        .valid_o(dly_valid)
    );

`ifdef BOOT_SEQ_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (go && ((state_q == S_IDLE) || (state_q == S_DONE))) csum_d = '0;
        else if (beat) csum_d = csum_q ^ load_data;
    end

    always_ff @(posedge clock) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign checksum = csum_q;
`endif

    assign pc           = addr_q;
    assign pc_in        = dly_addr;
    assign word_count   = wc_q;
    assign busy         = state_q != S_IDLE;
    assign done         = state_q == S_DONE;
    assign overflow     = overflow_q;
    assign mem_acc_size = ACC_SIZE_WORD;

endmodule
